// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial front end for a 4-bit 74181 alu: accepts one wide operation, ripples it through
// the alu LSB first with carry chaining, and returns the reassembled result on a valid/ready port.
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_s,
   input  logic                 in_m,
   input  logic [4*NIBBLES-1:0] in_a,
   input  logic [4*NIBBLES-1:0] in_b,
   input  logic                 in_cn,
   output logic [3:0]           alu_s,
   output logic                 alu_m,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic                 alu_cn,
   input  logic [3:0]           alu_f,
   input  logic                 alu_cn_4,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_f,
   output logic                 out_cn,
   output logic                 out_zero
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [3:0]       s_lat;
   logic             m_lat;
   logic [W-1:0]     a_lat;
   logic [W-1:0]     b_lat;
   logic             cn_lat;
   logic [W-1:0]     result;
   logic             carry_reg;
   logic [W-1:0]     result_nxt;
   logic [IDX_W+1:0] nib_base;

   assign nib_base = {idx, 2'b00};

   // The alu is combinational, so the nibble driven this cycle is merged into the result here.
   always_comb begin
      result_nxt = result;
      result_nxt[nib_base +: 4] = alu_f;
   end

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_zero  = (out_f == '0);

   assign alu_s  = s_lat;
   assign alu_m  = m_lat;
   assign alu_a  = (state == RUN) ? a_lat[nib_base +: 4] : 4'd0;
   assign alu_b  = (state == RUN) ? b_lat[nib_base +: 4] : 4'd0;
   assign alu_cn = (state == RUN) ? ((idx == '0) ? cn_lat : carry_reg) : 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         s_lat     <= 4'd0;
         m_lat     <= 1'b0;
         a_lat     <= '0;
         b_lat     <= '0;
         cn_lat    <= 1'b0;
         result    <= '0;
         carry_reg <= 1'b0;
         out_f     <= '0;
         out_cn    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s_lat  <= in_s;
                  m_lat  <= in_m;
                  a_lat  <= in_a;
                  b_lat  <= in_b;
                  cn_lat <= in_cn;
                  idx    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               result    <= result_nxt;
               carry_reg <= alu_cn_4;
               if (idx == LAST_IDX) begin
                  idx    <= '0;
                  out_f  <= result_nxt;
                  out_cn <= alu_cn_4;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 74181 closes the loop and a scoreboard queue
// holds the full-width result expected for each issued operation.
module tb_alu_nibble_sequencer;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct packed {
      logic [W-1:0] f;
      logic         cn;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_s;
   logic         in_m;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cn;
   logic [3:0]   alu_s;
   logic         alu_m;
   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic         alu_cn;
   logic [3:0]   alu_f;
   logic         alu_cn_4;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_f;
   logic         out_cn;
   logic         out_zero;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   acc_cyc;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_s(in_s), .in_m(in_m), .in_a(in_a), .in_b(in_b), .in_cn(in_cn),
      .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_cn_4(alu_cn_4),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_cn(out_cn), .out_zero(out_zero)
   );

   // One 74181 bit slice, carry c active-high; returns {carry_out, f}.
   function automatic logic [1:0] alu_bit(input logic [3:0] s, input logic m,
                                          input logic a, input logic b, input logic c);
      logic x, y, f, co;
      x  = ~(a | (b & s[0]) | (~b & s[1]));
      y  = ~((a & ~b & s[2]) | (a & b & s[3]));
      f  = ~(x ^ y) ^ (~m & ~c);
      co = ~y | (~x & c);
      return {co, f};
   endfunction

   function automatic logic [4:0] alu_nib(input logic [3:0] s, input logic m,
                                          input logic [3:0] a, input logic [3:0] b, input logic cn);
      logic       c;
      logic [1:0] r;
      logic [3:0] f;
      c = ~cn;
      for (int i = 0; i < 4; i++) begin
         r    = alu_bit(s, m, a[i], b[i], c);
         f[i] = r[0];
         c    = r[1];
      end
      return {~c, f};
   endfunction

   // Full-width reference: a plain W-bit ripple, no nibble structure.
   function automatic exp_t ref_op(input logic [3:0] s, input logic m,
                                   input logic [W-1:0] a, input logic [W-1:0] b, input logic cn);
      exp_t       e;
      logic       c;
      logic [1:0] r;
      c = ~cn;
      for (int i = 0; i < W; i++) begin
         r      = alu_bit(s, m, a[i], b[i], c);
         e.f[i] = r[0];
         c      = r[1];
      end
      e.cn = ~c;
      return e;
   endfunction

   assign {alu_cn_4, alu_f} = alu_nib(alu_s, alu_m, alu_a, alu_b, alu_cn);

   task automatic issue(input logic [3:0] s, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cn, input bit push);
      int n = 0;
      in_s = s; in_m = m; in_a = a; in_b = b; in_cn = cn; in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1; n++;
      end
      tests++;
      if (!in_ready) begin
         fails++;
         $display("FAIL issue_accept: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_s = 4'($urandom); in_cn = ~cn;
      if (push) exp_q.push_back(ref_op(s, m, a, b, cn));
   endtask

   task automatic wait_valid(output bit ok);
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      ok = out_valid;
      if (!ok) begin
         tests++; fails++;
         $display("FAIL wait_out_valid: out_valid=0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic run_capture(output logic [NIBBLES-1:0] cn_seq, output logic [NIBBLES-1:0] m_seq,
                              output logic [NIBBLES-1:0] v_seq, output logic [NIBBLES-1:0] r_seq);
      for (int k = 0; k < NIBBLES; k++) begin
         cn_seq[k] = alu_cn; m_seq[k] = alu_m; v_seq[k] = out_valid; r_seq[k] = in_ready;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_s = '0; in_m = 1'b0; in_a = '0; in_b = '0; in_cn = 1'b0;
      repeat (2) @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      tests++;
      if ({out_valid, out_f, out_cn, out_zero} !== {1'b0, {W{1'b0}}, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_outputs: valid=%b f=%h cn=%b zero=%b required 0 0000 0 1",
                  out_valid, out_f, out_cn, out_zero);
      end
      tests++;
      if ({alu_s, alu_m, alu_a, alu_b, alu_cn} !== 14'd0) begin
         fails++;
         $display("FAIL reset_alu_side: s=%h m=%b a=%h b=%h cn=%b required all 0",
                  alu_s, alu_m, alu_a, alu_b, alu_cn);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_chained_add();
      logic [NIBBLES-1:0] cn_seq, m_seq, v_seq, r_seq;
      exp_t e;
      bit ok;
      issue(4'b1001, 1'b0, 16'h1234, 16'h0FCD, 1'b1, 1'b1);
      tests++;
      if (alu_s !== 4'b1001) begin fails++; $display("FAIL add_alu_s: got %b required 1001", alu_s); end
      run_capture(cn_seq, m_seq, v_seq, r_seq);
      tests++;
      if (cn_seq !== 4'b0001) begin fails++; $display("FAIL add_cn_chain: got %b required 0001", cn_seq); end
      wait_valid(ok);
      e = exp_q.pop_front();
      if (ok) begin
         tests++;
         if (out_f !== 16'h2201 || out_f !== e.f) begin
            fails++; $display("FAIL add_out_f: got %h required 2201 (model %h)", out_f, e.f);
         end
         tests++;
         if (out_cn !== 1'b1 || out_cn !== e.cn || out_zero !== 1'b0) begin
            fails++; $display("FAIL add_cn_zero: cn=%b zero=%b required 1 0", out_cn, out_zero);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow_zero();
      exp_t e;
      bit ok;
      issue(4'b1001, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
      wait_valid(ok);
      e = exp_q.pop_front();
      if (ok) begin
         tests++;
         if (out_f !== 16'h0000 || out_f !== e.f || out_cn !== 1'b0 || out_cn !== e.cn || out_zero !== 1'b1) begin
            fails++;
            $display("FAIL overflow: f=%h cn=%b zero=%b required 0000 0 1", out_f, out_cn, out_zero);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_logic_xor();
      logic [NIBBLES-1:0] cn_seq, m_seq, v_seq, r_seq;
      exp_t e;
      bit ok;
      issue(4'b0110, 1'b1, 16'hA5A5, 16'hFFFF, 1'b1, 1'b1);
      run_capture(cn_seq, m_seq, v_seq, r_seq);
      tests++;
      if (m_seq !== 4'b1111) begin fails++; $display("FAIL xor_alu_m: got %b required 1111", m_seq); end
      wait_valid(ok);
      e = exp_q.pop_front();
      if (ok) begin
         tests++;
         if (out_f !== 16'h5A5A || out_f !== e.f || out_cn !== e.cn) begin
            fails++; $display("FAIL xor_out: f=%h cn=%b required 5a5a %b", out_f, out_cn, e.cn);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic [NIBBLES-1:0] cn_seq, m_seq, v_seq, r_seq;
      exp_t e;
      issue(4'b1001, 1'b0, 16'h00F0, 16'h0011, 1'b0, 1'b1);
      run_capture(cn_seq, m_seq, v_seq, r_seq);
      tests++;
      if (v_seq !== '0 || r_seq !== '0) begin
         fails++; $display("FAIL latency_run: out_valid=%b in_ready=%b required 0000 0000", v_seq, r_seq);
      end
      e = exp_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_f !== e.f) begin
         fails++;
         $display("FAIL latency_done: valid=%b ready=%b f=%h required 1 0 %h", out_valid, in_ready, out_f, e.f);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL latency_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      bit ok;
      logic [W-1:0] f0;
      logic cn0;
      int bad = 0;
      out_ready = 1'b0;
      issue(4'b1001, 1'b0, 16'h8888, 16'h8889, 1'b1, 1'b1);
      wait_valid(ok);
      e = exp_q.pop_front();
      f0 = out_f; cn0 = out_cn;
      tests++;
      if (f0 !== e.f || cn0 !== e.cn) begin
         fails++; $display("FAIL bp_result: f=%h cn=%b required %h %b", f0, cn0, e.f, e.cn);
      end
      in_valid = 1'b1; in_s = 4'b1001; in_a = 16'h1111; in_b = 16'h2222;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_f !== f0 || out_cn !== cn0 || in_ready !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
      repeat (NIBBLES + 2) @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_not_queued: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      bit ok;
      int bad = 0;
      issue(4'b1001, 1'b0, 16'h7777, 16'h1111, 1'b1, 1'b0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || out_f !== '0 || in_ready !== 1'b0 || alu_a !== 4'd0) begin
         fails++;
         $display("FAIL midrst_state: valid=%b f=%h ready=%b alu_a=%h required 0 0000 0 0",
                  out_valid, out_f, in_ready, alu_a);
      end
      rst_n = 1'b1;
      for (int k = 0; k < NIBBLES + 2; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL midrst_no_output: %0d bad cycles, required 0", bad); end
      issue(4'b1001, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b1);
      wait_valid(ok);
      e = exp_q.pop_front();
      if (ok) begin
         tests++;
         if (out_f !== 16'h0002 || out_f !== e.f || out_cn !== 1'b1) begin
            fails++; $display("FAIL midrst_fresh_add: f=%h cn=%b required 0002 1", out_f, out_cn);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [3:0] s_tab [4] = '{4'b1001, 4'b0110, 4'b0110, 4'b1011};
      logic       m_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_t e;
      bit ok;
      int prev = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         int sel = k % 4;
         issue(s_tab[sel], m_tab[sel], W'($urandom), W'($urandom), 1'($urandom), 1'b1);
         if (k > 0) begin
            tests++;
            if (acc_cyc - prev != NIBBLES + 2) begin
               fails++; $display("FAIL b2b_period: got %0d required %0d", acc_cyc - prev, NIBBLES + 2);
            end
         end
         prev = acc_cyc;
         wait_valid(ok);
         e = exp_q.pop_front();
         if (ok) begin
            tests++;
            if (out_f !== e.f || out_cn !== e.cn || out_zero !== (e.f == '0)) begin
               fails++;
               $display("FAIL b2b_result[%0d]: f=%h cn=%b zero=%b required %h %b %b",
                        k, out_f, out_cn, out_zero, e.f, e.cn, (e.f == '0));
            end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_chained_add();
      test_overflow_zero();
      test_logic_xor();
      test_latency();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Upstream controller for the 4-bit 74181 alu; one alu instance sits directly under it.
- Accepts one wide operation (op select, mode, two NIBBLES*4-bit operands, carry-in) on a valid/ready handshake.
- Issues it to the alu one nibble per cycle, LSB first, chaining each captured cn_4 into the next nibble's cn.
- Reassembles the full-width result and presents it on a valid/ready output handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; datapath width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  input  1  operation request valid
- in_ready  output  1  sequencer can accept an operation
- in_s  input  4  function select passed to alu s
- in_m  input  1  mode (0 arithmetic, 1 logic) passed to alu m
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cn  input  1  carry-in for nibble 0, alu polarity, passed unmodified
- alu_s  output  4  to alu s
- alu_m  output  1  to alu m
- alu_a  output  4  to alu a
- alu_b  output  4  to alu b
- alu_cn  output  1  to alu cn
- alu_f  input  4  from alu f
- alu_cn_4  input  1  from alu cn_4
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_f  output  W  assembled result
- out_cn  output  1  cn_4 of the most-significant nibble
- out_zero  output  1  high when out_f == 0

Behaviour:
- **FSM states:** IDLE, RUN, DONE.
- **Reset:** rst_n low at a rising edge forces:
  - state = IDLE; nibble index = 0;
  - latched op/operands = 0; result and carry registers = 0;
  - out_valid = 0, out_f = 0, out_cn = 0.
  - out_zero follows out_f, so it reads 1.
  - While rst_n is low, in_ready = 0.
  - A reset in RUN or DONE aborts the operation. No out_valid is produced for it.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch in_s, in_m, in_a, in_b, in_cn; idx <= 0; go to RUN.
- **RUN:**
  - in_ready = 0.
  - Drive alu_a = a_lat[4*idx+3:4*idx] and alu_b = b_lat[4*idx+3:4*idx].
  - Drive alu_cn = cn_lat when idx == 0, else carry_reg.
  - Every cycle: result[4*idx+3:4*idx] <= alu_f; carry_reg <= alu_cn_4; idx <= idx+1.
  - When idx == NIBBLES-1: go to DONE, load out_f from the completed result, out_cn <= alu_cn_4.
  - The alu is purely combinational, so capture happens in the same cycle the nibble is driven.
- **DONE:**
  - out_valid = 1. out_f, out_cn, out_zero are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE.
  - No accept occurs in the same cycle; in_ready rises the cycle after the output handshake.
- **ALU-side outputs:**
  - alu_s and alu_m = latched values in all states.
  - alu_a, alu_b, alu_cn = 0 outside RUN.
- **Mode handling:** carry chaining is identical for m = 1. alu_cn_4 is captured regardless; out_cn reports whatever the alu gives.
- **Latency:**
  - Accept at edge T; RUN occupies NIBBLES cycles; out_valid is high from edge T+NIBBLES onward.
  - Throughput is one operation per NIBBLES+2 cycles with out_ready tied high.
- **Input stability:**
  - in_* changing after acceptance has no effect.
  - in_valid in RUN or DONE is ignored and is not queued.
- **Output registers:** out_f and out_cn change only on entry to DONE or on reset.
- **Index width:** clog2(NIBBLES). No wrap-around beyond NIBBLES-1.

Test Plan:
- Chained add: NIBBLES=4; in_s=1001, in_m=0, in_cn=1 (no carry, 74181 active-low carry); A=0x1234, B=0x0FCD -> out_f=0x2201, out_cn=1, out_zero=0. alu_cn per RUN cycle = 1,0,0,0.
- Overflow/zero: add, in_cn=1, A=0xFFFF, B=0x0001 -> out_f=0x0000, out_cn=0, out_zero=1.
- Logic XOR: in_s=0110, in_m=1, A=0xA5A5, B=0xFFFF -> out_f=0x5A5A. alu_m=1 throughout RUN.
- Latency/handshake: accept at edge T, out_ready=1 -> out_valid first high after edge T+4 for exactly one cycle. in_ready low from T+1 until the cycle after the output handshake.
- Backpressure: out_ready low for 6 cycles in DONE -> out_valid, out_f, out_cn stable; in_ready=0; new in_valid ignored; release -> IDLE next cycle.
- Reset mid-RUN: rst_n low at idx=2 -> next cycle state IDLE, out_valid=0, out_f=0. A fresh add of 0x0001+0x0001 (cn=1) then yields out_f=0x0002.
